// File: rtl/cpu_pkg.sv
// Shared types and encodings for the instruction controller: FSM states,
// instruction classes, opcode/op fields and writeback-select codes.
package cpu_pkg;

    typedef enum logic [2:0] {
        WAIT,
        DECODE,
        WR_IMM,
        GET_A,
        GET_B,
        COMPUTE,
        WR_RD
    } state_t;

    typedef enum logic [2:0] {
        CLS_ILLEGAL,
        CLS_MOV_IMM,
        CLS_MOV_REG,
        CLS_ADD,
        CLS_CMP,
        CLS_AND,
        CLS_MVN
    } instr_cls_t;

    localparam logic [2:0] OPC_MOV    = 3'b110;
    localparam logic [2:0] OPC_ALU    = 3'b101;

    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    localparam logic [1:0] VSEL_C     = 2'b00;
    localparam logic [1:0] VSEL_IMM   = 2'b10;

    function automatic instr_cls_t classify(input logic [2:0] opcode, input logic [1:0] op);
        instr_cls_t cls;
        cls = CLS_ILLEGAL;
        case (opcode)
            OPC_MOV: begin
                if (op == OP_MOV_IMM)      cls = CLS_MOV_IMM;
                else if (op == OP_MOV_REG) cls = CLS_MOV_REG;
            end
            OPC_ALU: begin
                case (op)
                    OP_ADD:  cls = CLS_ADD;
                    OP_CMP:  cls = CLS_CMP;
                    OP_AND:  cls = CLS_AND;
                    default: cls = CLS_MVN;
                endcase
            end
            default: cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/cpu_controller_if.sv
// Instruction input handshake plus register-file and datapath control outputs.
interface cpu_controller_if;
    logic [15:0] in;
    logic        load;
    logic        s;
    logic        w;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic        write;
    logic        loada;
    logic        loadb;
    logic        loadc;
    logic        loads;
    logic        asel;
    logic        bsel;
    logic [1:0]  vsel;
    logic [1:0]  ALUop;
    logic [1:0]  shift;
    logic [15:0] sximm8;
    logic [15:0] sximm5;

    modport master (
        output in, load, s,
        input  w, readnum, writenum, write, loada, loadb, loadc, loads,
               asel, bsel, vsel, ALUop, shift, sximm8, sximm5
    );

    modport slave (
        input  in, load, s,
        output w, readnum, writenum, write, loada, loadb, loadc, loads,
               asel, bsel, vsel, ALUop, shift, sximm8, sximm5
    );
endinterface

// File: rtl/cpu_controller_instr_decoder.sv
// Combinational field extraction, classification and sign extension of the
// instruction register.
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [15:0] ir_i,
    output instr_cls_t  cls_o,
    output logic [1:0]  op_o,
    output logic [1:0]  sh_o,
    output logic [2:0]  rn_o,
    output logic [2:0]  rd_o,
    output logic [2:0]  rm_o,
    output logic [15:0] sximm8_o,
    output logic [15:0] sximm5_o
);

    assign cls_o    = classify(ir_i[15:13], ir_i[12:11]);
    assign op_o     = ir_i[12:11];
    assign rn_o     = ir_i[10:8];
    assign rd_o     = ir_i[7:5];
    assign sh_o     = ir_i[4:3];
    assign rm_o     = ir_i[2:0];
    assign sximm8_o = {{8{ir_i[7]}}, ir_i[7:0]};
    assign sximm5_o = {{11{ir_i[4]}}, ir_i[4:0]};

endmodule

// File: rtl/cpu_controller.sv
// Instruction register and control FSM sequencing one register-file access per
// cycle; all control outputs are Moore functions of state and IR.
module cpu_controller
    import cpu_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic            clk,
    input  logic            reset,
    cpu_controller_if.slave bus
);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] ir_q, ir_d;

    instr_cls_t  cls;
    logic [1:0]  op, sh;
    logic [2:0]  rn, rd, rm;

    instr_decoder u_dec (
        .ir_i     (ir_q),
        .cls_o    (cls),
        .op_o     (op),
        .sh_o     (sh),
        .rn_o     (rn),
        .rd_o     (rd),
        .rm_o     (rm),
        .sximm8_o (bus.sximm8),
        .sximm5_o (bus.sximm5)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= WAIT;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    // IR only changes in WAIT, so it is stable for the whole instruction
    always_comb begin
        ir_d = ir_q;
        if (state_q == WAIT && bus.load) ir_d = bus.in;
    end

    assign bus.ALUop = (cls inside {CLS_ADD, CLS_CMP, CLS_AND, CLS_MVN}) ? op : 2'b00;
    assign bus.shift = (cls == CLS_MOV_IMM) ? 2'b00 : sh;
    assign bus.bsel  = 1'b0;

    always_comb begin
        state_d      = state_q;
        bus.w        = 1'b0;
        bus.readnum  = '0;
        bus.writenum = '0;
        bus.write    = 1'b0;
        bus.loada    = 1'b0;
        bus.loadb    = 1'b0;
        bus.loadc    = 1'b0;
        bus.loads    = 1'b0;
        bus.asel     = 1'b0;
        bus.vsel     = VSEL_C;
        case (state_q)
            WAIT: begin
                bus.w = 1'b1;
                if (bus.s) state_d = DECODE;
            end
            DECODE: begin
                case (cls)
                    CLS_MOV_IMM:                 state_d = WR_IMM;
                    CLS_MOV_REG, CLS_MVN:        state_d = GET_B;
                    CLS_ADD, CLS_CMP, CLS_AND:   state_d = GET_A;
                    default:                     state_d = WAIT;
                endcase
            end
            WR_IMM: begin
                bus.writenum = rn;
                bus.vsel     = VSEL_IMM;
                bus.write    = 1'b1;
                state_d      = WAIT;
            end
            GET_A: begin
                bus.readnum = rn;
                bus.loada   = 1'b1;
                state_d     = GET_B;
            end
            GET_B: begin
                bus.readnum = rm;
                bus.loadb   = 1'b1;
                state_d     = COMPUTE;
            end
            COMPUTE: begin
                bus.asel  = (cls == CLS_MOV_REG) || (cls == CLS_MVN);
                bus.loads = 1'b1;
                // CMP only updates status and never reaches writeback
                if (cls == CLS_CMP) begin
                    state_d = WAIT;
                end else begin
                    bus.loadc = 1'b1;
                    state_d   = WR_RD;
                end
            end
            WR_RD: begin
                bus.writenum = rd;
                bus.vsel     = VSEL_C;
                bus.write    = 1'b1;
                state_d      = WAIT;
            end
            default: state_d = WAIT;
        endcase
    end

endmodule

// File: tb/tb_cpu_controller.sv
// Bench for cpu_controller: directed scenarios plus randomized instructions
// against a step-list reference model of each instruction's register accesses.
module tb_cpu_controller;

    typedef struct packed {
        logic       w;
        logic [2:0] readnum;
        logic [2:0] writenum;
        logic       write;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
        logic [1:0] vsel;
    } ctl_t;

    typedef struct packed {
        logic [1:0]  aluop;
        logic [1:0]  shift;
        logic [15:0] sximm8;
        logic [15:0] sximm5;
    } fld_t;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    cpu_controller_if bus ();

    cpu_controller #(.DATA_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    ctl_t act_ctl;
    fld_t act_fld;
    assign act_ctl = {bus.w, bus.readnum, bus.writenum, bus.write, bus.loada, bus.loadb,
                      bus.loadc, bus.loads, bus.asel, bus.bsel, bus.vsel};
    assign act_fld = {bus.ALUop, bus.shift, bus.sximm8, bus.sximm5};

    ctl_t obs_ctl[$];
    fld_t obs_fld[$];
    ctl_t exp_q[$];

    localparam ctl_t BUSY = '0;
    localparam ctl_t IDLE = 16'h8000;

    // Expected per-cycle sequence: decode, then each register-file access step, then idle
    task automatic build_model(input logic [15:0] ins);
        ctl_t c;
        bit is_mov, is_alu, is_cmp, reads_a;
        is_mov  = (ins[15:13] == 3'b110);
        is_alu  = (ins[15:13] == 3'b101);
        is_cmp  = is_alu && ins[12:11] == 2'b01;
        reads_a = is_alu && ins[12:11] != 2'b11;
        exp_q.delete();
        exp_q.push_back(BUSY);
        if (is_mov && ins[12:11] == 2'b10) begin
            c = '0; c.writenum = ins[10:8]; c.vsel = 2'b10; c.write = 1'b1;
            exp_q.push_back(c);
        end else if ((is_mov && ins[12:11] == 2'b00) || is_alu) begin
            if (reads_a) begin
                c = '0; c.readnum = ins[10:8]; c.loada = 1'b1;
                exp_q.push_back(c);
            end
            c = '0; c.readnum = ins[2:0]; c.loadb = 1'b1;
            exp_q.push_back(c);
            c = '0; c.loads = 1'b1; c.loadc = !is_cmp; c.asel = !reads_a;
            exp_q.push_back(c);
            if (!is_cmp) begin
                c = '0; c.writenum = ins[7:5]; c.write = 1'b1;
                exp_q.push_back(c);
            end
        end
        exp_q.push_back(IDLE);
    endtask

    function automatic fld_t model_fields(input logic [15:0] ins);
        fld_t f;
        int   v8, v5;
        v8 = int'(ins[7:0]);
        if (v8 > 127) v8 = v8 - 256;
        v5 = int'(ins[4:0]);
        if (v5 > 15) v5 = v5 - 32;
        f.aluop  = (ins[15:13] == 3'b101) ? ins[12:11] : 2'b00;
        f.shift  = (ins[15:11] == 5'b11010) ? 2'b00 : ins[4:3];
        f.sximm8 = 16'(v8);
        f.sximm5 = 16'(v5);
        return f;
    endfunction

    // Issue one instruction with load+s, recording outputs each cycle until idle
    task automatic run(input logic [15:0] ins, input bit noise);
        int budget;
        obs_ctl.delete();
        obs_fld.delete();
        budget = 16;
        while (bus.w !== 1'b1 && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        if (bus.w !== 1'b1) begin
            n_checks++; n_fail++;
            $display("FAIL run_wait_idle: w=%b required 1", bus.w);
        end
        @(negedge clk);
        bus.in = ins; bus.load = 1'b1; bus.s = 1'b1;
        @(posedge clk); #1;
        bus.load = 1'b0; bus.s = 1'b0;
        obs_ctl.push_back(act_ctl); obs_fld.push_back(act_fld);
        budget = 12;
        while (bus.w !== 1'b1 && budget > 0) begin
            @(negedge clk);
            if (noise) begin
                bus.in   = 16'($urandom);
                bus.load = 1'($urandom_range(0, 1));
                bus.s    = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
            bus.load = 1'b0; bus.s = 1'b0;
            obs_ctl.push_back(act_ctl); obs_fld.push_back(act_fld);
            budget--;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (act_ctl !== IDLE) begin
            n_fail++; $display("FAIL reset_ctl: got %h required %h", act_ctl, IDLE);
        end
        n_checks++;
        if (act_fld !== '0) begin
            n_fail++; $display("FAIL reset_fields: got %h required 0", act_fld);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_mov_imm();
        ctl_t e;
        run(16'hD007, 1'b0);
        n_checks++;
        if (obs_ctl.size() !== 3) begin
            n_fail++; $display("FAIL mov_imm_len: got %0d required 3", obs_ctl.size());
        end
        if (obs_ctl.size() >= 3) begin
            e = '0; e.writenum = 3'd0; e.vsel = 2'b10; e.write = 1'b1;
            n_checks++;
            if (obs_ctl[1] !== e) begin
                n_fail++; $display("FAIL mov_imm_write: got %h required %h", obs_ctl[1], e);
            end
            n_checks++;
            if (obs_fld[1].sximm8 !== 16'h0007) begin
                n_fail++; $display("FAIL mov_imm_sximm8: got %h required 0007", obs_fld[1].sximm8);
            end
            n_checks++;
            if (obs_ctl[2] !== IDLE) begin
                n_fail++; $display("FAIL mov_imm_idle: got %h required %h", obs_ctl[2], IDLE);
            end
        end
    endtask

    task automatic test_mov_imm_neg();
        run(16'hD5FF, 1'b0);
        n_checks++;
        if (obs_ctl.size() !== 3) begin
            n_fail++; $display("FAIL mov_neg_len: got %0d required 3", obs_ctl.size());
        end
        if (obs_ctl.size() >= 2) begin
            n_checks++;
            if (obs_fld[1].sximm8 !== 16'hFFFF) begin
                n_fail++; $display("FAIL mov_neg_sximm8: got %h required ffff", obs_fld[1].sximm8);
            end
            n_checks++;
            if (obs_ctl[1].writenum !== 3'd5 || obs_ctl[1].write !== 1'b1) begin
                n_fail++; $display("FAIL mov_neg_write: got wn=%0d wr=%b required wn=5 wr=1",
                                   obs_ctl[1].writenum, obs_ctl[1].write);
            end
        end
    endtask

    task automatic test_add();
        ctl_t e[6];
        run(16'hA041, 1'b0);
        e[0] = BUSY;
        e[1] = '0; e[1].readnum = 3'd0; e[1].loada = 1'b1;
        e[2] = '0; e[2].readnum = 3'd1; e[2].loadb = 1'b1;
        e[3] = '0; e[3].loadc = 1'b1; e[3].loads = 1'b1;
        e[4] = '0; e[4].writenum = 3'd2; e[4].write = 1'b1;
        e[5] = IDLE;
        n_checks++;
        if (obs_ctl.size() !== 6) begin
            n_fail++; $display("FAIL add_len: got %0d required 6", obs_ctl.size());
        end
        for (int i = 0; i < 6 && i < obs_ctl.size(); i++) begin
            n_checks++;
            if (obs_ctl[i] !== e[i]) begin
                n_fail++; $display("FAIL add_cycle%0d: got %h required %h", i, obs_ctl[i], e[i]);
            end
        end
        n_checks++;
        if (obs_fld[0].aluop !== 2'b00) begin
            n_fail++; $display("FAIL add_aluop: got %b required 00", obs_fld[0].aluop);
        end
    endtask

    task automatic test_cmp_mvn();
        run(16'hA801, 1'b0);
        n_checks++;
        if (obs_ctl.size() !== 5) begin
            n_fail++; $display("FAIL cmp_len: got %0d required 5", obs_ctl.size());
        end
        if (obs_ctl.size() >= 4) begin
            n_checks++;
            if (obs_ctl[3].loads !== 1'b1 || obs_ctl[3].loadc !== 1'b0) begin
                n_fail++; $display("FAIL cmp_compute: got loads=%b loadc=%b required 1 0",
                                   obs_ctl[3].loads, obs_ctl[3].loadc);
            end
        end
        foreach (obs_ctl[i]) begin
            n_checks++;
            if (obs_ctl[i].write !== 1'b0) begin
                n_fail++; $display("FAIL cmp_nowrite%0d: got %b required 0", i, obs_ctl[i].write);
            end
        end
        run(16'hB861, 1'b0);
        n_checks++;
        if (obs_ctl.size() !== 5) begin
            n_fail++; $display("FAIL mvn_len: got %0d required 5", obs_ctl.size());
        end
        if (obs_ctl.size() >= 4) begin
            n_checks++;
            if (obs_ctl[2].asel !== 1'b1 || obs_fld[2].aluop !== 2'b11) begin
                n_fail++; $display("FAIL mvn_compute: got asel=%b aluop=%b required 1 11",
                                   obs_ctl[2].asel, obs_fld[2].aluop);
            end
            n_checks++;
            if (obs_ctl[3].writenum !== 3'd3 || obs_ctl[3].write !== 1'b1) begin
                n_fail++; $display("FAIL mvn_write: got wn=%0d wr=%b required 3 1",
                                   obs_ctl[3].writenum, obs_ctl[3].write);
            end
        end
    endtask

    task automatic test_illegal_ignore();
        run(16'h0000, 1'b1);
        n_checks++;
        if (obs_ctl.size() !== 2) begin
            n_fail++; $display("FAIL illegal_len: got %0d required 2", obs_ctl.size());
        end
        foreach (obs_ctl[i]) begin
            n_checks++;
            if (obs_ctl[i] !== (i == 0 ? BUSY : IDLE) || obs_fld[i] !== '0) begin
                n_fail++; $display("FAIL illegal_cycle%0d: got %h/%h required no strobes, IR 0",
                                   i, obs_ctl[i], obs_fld[i]);
            end
        end
        run(16'hA041, 1'b1);
        build_model(16'hA041);
        n_checks++;
        if (obs_ctl.size() !== exp_q.size()) begin
            n_fail++; $display("FAIL noisy_add_len: got %0d required %0d", obs_ctl.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_ctl.size(); i++) begin
            n_checks++;
            if (obs_ctl[i] !== exp_q[i] || obs_fld[i] !== model_fields(16'hA041)) begin
                n_fail++; $display("FAIL noisy_add_cycle%0d: got %h/%h required %h/%h", i,
                                   obs_ctl[i], obs_fld[i], exp_q[i], model_fields(16'hA041));
            end
        end
    endtask

    task automatic test_load_then_start();
        ctl_t e;
        @(negedge clk);
        bus.in = 16'hD123; bus.load = 1'b1; bus.s = 1'b0;
        @(posedge clk); #1;
        bus.load = 1'b0;
        n_checks++;
        if (act_ctl !== IDLE || act_fld.sximm8 !== 16'h0023) begin
            n_fail++; $display("FAIL load_only: got %h sximm8=%h required %h 0023",
                               act_ctl, act_fld.sximm8, IDLE);
        end
        @(negedge clk);
        bus.in = 16'hFFFF; bus.s = 1'b1;
        @(posedge clk); #1;
        bus.s = 1'b0;
        n_checks++;
        if (act_ctl !== BUSY) begin
            n_fail++; $display("FAIL start_only_decode: got %h required %h", act_ctl, BUSY);
        end
        @(posedge clk); #1;
        e = '0; e.writenum = 3'd1; e.vsel = 2'b10; e.write = 1'b1;
        n_checks++;
        if (act_ctl !== e || act_fld.sximm8 !== 16'h0023) begin
            n_fail++; $display("FAIL start_only_write: got %h sximm8=%h required %h 0023",
                               act_ctl, act_fld.sximm8, e);
        end
        @(posedge clk); #1;
        n_checks++;
        if (act_ctl !== IDLE) begin
            n_fail++; $display("FAIL start_only_idle: got %h required %h", act_ctl, IDLE);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus.in = 16'hA041; bus.load = 1'b1; bus.s = 1'b1;
        @(posedge clk); #1;
        bus.load = 1'b0; bus.s = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        n_checks++;
        if (act_ctl.loadb !== 1'b1 || act_ctl.readnum !== 3'd1) begin
            n_fail++; $display("FAIL rst_mid_getb: got %h required loadb=1 readnum=1", act_ctl);
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (act_ctl !== IDLE || act_fld !== '0) begin
            n_fail++; $display("FAIL rst_mid_async: got %h/%h required %h/0", act_ctl, act_fld, IDLE);
        end
        @(posedge clk); #1;
        n_checks++;
        if (act_ctl !== IDLE) begin
            n_fail++; $display("FAIL rst_mid_hold: got %h required %h", act_ctl, IDLE);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_random();
        logic [15:0] ins;
        fld_t        f;
        for (int n = 0; n < 40; n++) begin
            ins = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       ins[15:13] = 3'b110;
                1, 2:    ins[15:13] = 3'b101;
                default: ;
            endcase
            run(ins, 1'b1);
            build_model(ins);
            f = model_fields(ins);
            n_checks++;
            if (obs_ctl.size() !== exp_q.size()) begin
                n_fail++; $display("FAIL rand_len ins=%h: got %0d required %0d",
                                   ins, obs_ctl.size(), exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < obs_ctl.size(); i++) begin
                n_checks++;
                if (obs_ctl[i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL rand_ctl ins=%h cyc%0d: got %h required %h",
                                       ins, i, obs_ctl[i], exp_q[i]);
                end
                n_checks++;
                if (obs_fld[i] !== f) begin
                    n_fail++; $display("FAIL rand_fld ins=%h cyc%0d: got %h required %h",
                                       ins, i, obs_fld[i], f);
                end
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        bus.in   = '0;
        bus.load = 1'b0;
        bus.s    = 1'b0;
        test_reset();
        test_mov_imm();
        test_mov_imm_neg();
        test_add();
        test_cmp_mvn();
        test_illegal_ignore();
        test_load_then_start();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
